regfile_wb: RTL

Writeback-stage register file for the 16-bit single-cycle datapath. It consumes the result selected from the ALU/SLLI output mux, writes it into one of four 16-bit general registers on the clock edge, and supplies both operand read ports to the execute stage. It also latches Zero/Negative flags from the written-back result and keeps a retired-write counter for bench and debug visibility.

---
 rtl/cpu16_pkg.sv | 27 ++
 rtl/regfile_read_port.sv | 39 +++
 rtl/regfile_wb.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared constants and types for the 16-bit single-cycle datapath.
// Decode, the ALU/SLLI result mux and the writeback register file all import this package.
package cpu16_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 2;
  localparam int REG_COUNT = 4;
  localparam int RETIRE_W  = 16;

  localparam logic [ADDR_W-1:0]   R0_IDX    = '0;
  localparam logic [DATA_W-1:0]   RESET_VAL = 16'h0000;
  localparam logic [RETIRE_W-1:0] RETIRE_RESET = '0;

  typedef struct packed {
    logic zero;
    logic neg;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{zero: 1'b0, neg: 1'b0};

  // A write lands in the array only when it targets a real register.
  function automatic logic is_array_write(input logic reg_write,
                                          input logic [ADDR_W-1:0] write_reg);
    return reg_write && (write_reg != R0_IDX);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One operand read port: combinational array read with write-through bypass.
// R0 always reads as zero, and the port outputs zero while reset is held.
module regfile_read_port
  import cpu16_pkg::*;
#(
  parameter int P_DATA_W    = DATA_W,
  parameter int P_ADDR_W    = ADDR_W,
  parameter int P_REG_COUNT = REG_COUNT
) (
  input  logic                  reset_n,
  input  logic                  reg_write,
  input  logic [P_ADDR_W-1:0]   write_reg,
  input  logic [P_DATA_W-1:0]   write_data,
  input  logic [P_ADDR_W-1:0]   read_reg,
  input  logic [P_DATA_W-1:0]   regs [P_REG_COUNT],
  output logic [P_DATA_W-1:0]   read_data
);

  logic bypass_hit;

  always_comb begin
    bypass_hit = reg_write && (write_reg != '0) && (write_reg == read_reg);
  end

  // Bypass is gated by reset so a write attempted during reset never leaks out.
  always_comb begin
    read_data = '0;
    if (!reset_n) begin
      read_data = '0;
    end else if (bypass_hit) begin
      read_data = write_data;
    end else if (read_reg == '0) begin
      read_data = '0;
    end else begin
      read_data = regs[read_reg];
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback-stage register file: four 16-bit registers (R0 hardwired zero),
// two bypassed read ports, Zero/Negative result flags and a retired-write counter.
module regfile_wb
  import cpu16_pkg::*;
#(
  parameter int DATA_W    = cpu16_pkg::DATA_W,
  parameter int ADDR_W    = cpu16_pkg::ADDR_W,
  parameter int REG_COUNT = cpu16_pkg::REG_COUNT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   WriteReg,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic                FlagUpdate,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                ZeroFlag,
  output logic                NegFlag,
  output logic [15:0]         RetireCount
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  flags_t            flags_q;
  flags_t            flags_d;
  logic [15:0]       retire_cnt_q;
  logic [15:0]       retire_cnt_d;

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (RegWrite && (WriteReg != '0)) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    flags_d = flags_q;
    if (FlagUpdate) begin
      flags_d.zero = (WriteData == '0);
      flags_d.neg  = WriteData[DATA_W-1];
    end
  end

  // Counts every RegWrite cycle, R0 included; wraps silently.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (RegWrite) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      flags_q      <= FLAGS_RESET;
      retire_cnt_q <= RETIRE_RESET;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q      <= flags_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  regfile_read_port #(
    .P_DATA_W    (DATA_W),
    .P_ADDR_W    (ADDR_W),
    .P_REG_COUNT (REG_COUNT)
  ) u_read_port1 (
    .reset_n    (Reset),
    .reg_write  (RegWrite),
    .write_reg  (WriteReg),
    .write_data (WriteData),
    .read_reg   (ReadReg1),
    .regs       (regs_q),
    .read_data  (ReadData1)
  );

  regfile_read_port #(
    .P_DATA_W    (DATA_W),
    .P_ADDR_W    (ADDR_W),
    .P_REG_COUNT (REG_COUNT)
  ) u_read_port2 (
    .reset_n    (Reset),
    .reg_write  (RegWrite),
    .write_reg  (WriteReg),
    .write_data (WriteData),
    .read_reg   (ReadReg2),
    .regs       (regs_q),
    .read_data  (ReadData2)
  );

  assign ZeroFlag    = flags_q.zero;
  assign NegFlag     = flags_q.neg;
  assign RetireCount = retire_cnt_q;

endmodule
